elevator_ctrl: RTL and testbench

//  Cycle-based controller for the 3-floor car. Latches hall/car calls into
//  per-floor request lamps, picks the goal floor (SCAN policy), runs travel
//  and door-dwell timing and reports floor/moving. Its floor, led1..3 and

---
 rtl/elevator_ctrl_pkg.sv | 51 +++++
 rtl/elevator_ctrl_if.sv | 32 +++
 rtl/elevator_ctrl_dwell_timer.sv | 30 +++
 rtl/elevator_ctrl.sv | 176 +++++++++++++++++
 tb/tb_elevator_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_ctrl_pkg.sv
// Shared types and helpers for the 3-floor elevator controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: controller state encoding, floor-index constants, goal record type,
// and nearest-pending-floor search functions used by the goal selector.
package elevator_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    // Internal floor indices; output codes come from the LABEL_Fx parameters.
    localparam logic [1:0] IDX_F1 = 2'd0;
    localparam logic [1:0] IDX_F3 = 2'd2;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } goal_t;

    // Nearest pending floor strictly above cur. The scan runs top-down, so the
    // last hit is the closest one.
    function automatic goal_t nearest_above(input logic [1:0] cur, input logic [2:0] pend);
        goal_t r;
        r = '0;
        for (int i = 2; i >= 0; i--) begin
            if (i > int'(cur) && pend[i]) begin
                r.found = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

    // Nearest pending floor strictly below cur (bottom-up scan, last hit wins).
    function automatic goal_t nearest_below(input logic [1:0] cur, input logic [2:0] pend);
        goal_t r;
        r = '0;
        for (int i = 0; i <= 2; i++) begin
            if (i < int'(cur) && pend[i]) begin
                r.found = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Call/status bundle between the elevator controller and its environment.
// Latency: n/a (wires only).
// Backpressure: none; btn is a pulse input, all status signals are levels.
// Signals: btn[2:0] call pulses, floor/gf label-coded, led1..3 request lamps,
// moving, dir (1=up), door_open; estop only when ELEVATOR_ESTOP_EN is defined.
// master = call source / status observer, slave = controller.
interface elevator_ctrl_if;
    logic [2:0] btn;
`ifdef ELEVATOR_ESTOP_EN
    logic       estop;
`endif
    logic [1:0] floor;
    logic       led1;
    logic       led2;
    logic       led3;
    logic       moving;
    logic       dir;
    logic       door_open;
    logic [1:0] gf;

`ifdef ELEVATOR_ESTOP_EN
    modport master (output btn, estop,
                    input  floor, led1, led2, led3, moving, dir, door_open, gf);
    modport slave  (input  btn, estop,
                    output floor, led1, led2, led3, moving, dir, door_open, gf);
`else
    modport master (output btn,
                    input  floor, led1, led2, led3, moving, dir, door_open, gf);
    modport slave  (input  btn,
                    output floor, led1, led2, led3, moving, dir, door_open, gf);
`endif
endinterface

// File: rtl/elevator_ctrl_dwell_timer.sv
// Down-counter shared by the travel and door-dwell phases.
// Latency: expire_o asserts while the count is 1, i.e. N clocks after a load of N.
// Backpressure: freeze_i holds the count and masks expire_o; load_i wins over both.
// Ports: clk, rst (sync, active high), load_i/load_val_i, freeze_i, expire_o.
module elevator_ctrl_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         freeze_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (!freeze_i && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_o = !freeze_i && (cnt_q == W'(1));

endmodule

// File: rtl/elevator_ctrl.sv
// 3-floor elevator controller: call latching, SCAN goal selection, travel and door timing.
// Latency: call -> lamp 1 clk, call -> moving 2 clk, TRAVEL_CYCLES per floor, DOOR_CYCLES dwell.
// Backpressure: none on calls; with ELEVATOR_ESTOP_EN, estop freezes timers/state, calls still latch.
// Ports: clk, rst (sync, active high), bus (elevator_ctrl_if.slave). All outputs registered.
// Optional feature macro: ELEVATOR_ESTOP_EN (adds bus.estop and the freeze path).
module elevator_ctrl
    import elevator_ctrl_pkg::*;
#(
    parameter logic [1:0] LABEL_F1      = 2'b00,
    parameter logic [1:0] LABEL_F2      = 2'b01,
    parameter logic [1:0] LABEL_F3      = 2'b10,
    parameter int         TRAVEL_CYCLES = 8,
    parameter int         DOOR_CYCLES   = 6
) (
    input  logic            clk,
    input  logic            rst,
    elevator_ctrl_if.slave  bus
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    function automatic logic [1:0] to_label(input logic [1:0] idx);
        case (idx)
            2'd0:    return LABEL_F1;
            2'd1:    return LABEL_F2;
            default: return LABEL_F3;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [1:0] floor_idx_q, floor_idx_d;
    logic [1:0] floor_lbl_q;
    logic [1:0] gf_q, gf_d;
    logic [2:0] pend_q, pend_d;
    logic       dir_q, dir_d;
    logic       moving_q, moving_d;
    logic       door_q, door_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;
    logic          frozen;

    goal_t      above, below, pick;
    logic [1:0] arr_idx;

`ifdef ELEVATOR_ESTOP_EN
    assign frozen = bus.estop;
`else
    assign frozen = 1'b0;
`endif

    elevator_ctrl_dwell_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .freeze_i   (frozen),
        .expire_o   (tmr_expire)
    );

    // SCAN: keep going the way we last went if anything is pending that way.
    assign above = nearest_above(floor_idx_q, pend_q);
    assign below = nearest_below(floor_idx_q, pend_q);
    assign pick  = dir_q ? (above.found ? above : below)
                         : (below.found ? below : above);

    // Floor reached at the end of the current hop, clamped to the shaft.
    assign arr_idx = (state_q == ST_MOVE_UP)
                   ? ((floor_idx_q == IDX_F3) ? IDX_F3 : floor_idx_q + 2'd1)
                   : ((floor_idx_q == IDX_F1) ? IDX_F1 : floor_idx_q - 2'd1);

    always_comb begin
        state_d     = state_q;
        floor_idx_d = floor_idx_q;
        gf_d        = gf_q;
        pend_d      = pend_q | bus.btn;
        dir_d       = dir_q;
        moving_d    = moving_q;
        door_d      = door_q;
        tmr_load    = 1'b0;
        tmr_val     = TW'(TRAVEL_CYCLES);

        if (frozen) begin
            moving_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A call (or a lamp latched during estop) at the current floor
                    // just opens the door.
                    if (pend_q[floor_idx_q] || bus.btn[floor_idx_q]) begin
                        pend_d[floor_idx_q] = 1'b0;
                        door_d   = 1'b1;
                        state_d  = ST_DOOR;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(DOOR_CYCLES);
                    end else if (pick.found) begin
                        gf_d     = to_label(pick.idx);
                        moving_d = 1'b1;
                        tmr_load = 1'b1;
                        if (pick.idx > floor_idx_q) begin
                            state_d = ST_MOVE_UP;
                            dir_d   = 1'b1;
                        end else begin
                            state_d = ST_MOVE_DOWN;
                            dir_d   = 1'b0;
                        end
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    moving_d = 1'b1;
                    if (tmr_expire) begin
                        floor_idx_d = arr_idx;
                        // Stop at any pending floor, including a call arriving this cycle.
                        if (pend_q[arr_idx] || bus.btn[arr_idx]) begin
                            pend_d[arr_idx] = 1'b0;
                            moving_d = 1'b0;
                            door_d   = 1'b1;
                            state_d  = ST_DOOR;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(DOOR_CYCLES);
                        end else begin
                            tmr_load = 1'b1;
                        end
                    end
                end
                ST_DOOR: begin
                    if (bus.btn[floor_idx_q]) begin
                        pend_d[floor_idx_q] = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(DOOR_CYCLES);
                    end else if (tmr_expire) begin
                        door_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            floor_idx_q <= IDX_F1;
            floor_lbl_q <= LABEL_F1;
            gf_q        <= LABEL_F1;
            pend_q      <= '0;
            dir_q       <= 1'b1;
            moving_q    <= 1'b0;
            door_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_idx_q <= floor_idx_d;
            floor_lbl_q <= to_label(floor_idx_d);
            gf_q        <= gf_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            moving_q    <= moving_d;
            door_q      <= door_d;
        end
    end

    assign bus.floor     = floor_lbl_q;
    assign bus.gf        = gf_q;
    assign bus.led1      = pend_q[0];
    assign bus.led2      = pend_q[1];
    assign bus.led3      = pend_q[2];
    assign bus.moving    = moving_q;
    assign bus.dir       = dir_q;
    assign bus.door_open = door_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
// Edge counts in comments are relative to the edge that samples each call (e1).
// Outputs are sampled 1 time unit after the rising edge.
module tb_elevator_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    elevator_ctrl_if bus ();

    elevator_ctrl #(
        .LABEL_F1      (2'b00),
        .LABEL_F2      (2'b01),
        .LABEL_F3      (2'b10),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] b);
        bus.btn = b;
        tick(1);
        bus.btn = '0;
    endtask

    function automatic logic [2:0] leds();
        return {bus.led3, bus.led2, bus.led1};
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.btn  = '0;
`ifdef ELEVATOR_ESTOP_EN
        bus.estop = 1'b0;
`endif

        // Reset values
        tick(2);
        chk("rst_floor", bus.floor, 2'b00);
        chk("rst_leds", leds(), 3'b000);
        chk("rst_moving", bus.moving, 1'b0);
        chk("rst_door", bus.door_open, 1'b0);
        chk("rst_gf", bus.gf, 2'b00);
        chk("rst_dir", bus.dir, 1'b1);
        rst = 1'b0;
        tick(1);
        chk("idle_moving", bus.moving, 1'b0);

        // F1 -> F3 trip
        press(3'b100);                                 // e1
        chk("t1_led3", leds(), 3'b100);
        chk("t1_mv_e1", bus.moving, 1'b0);
        tick(1);                                       // e2
        chk("t1_mv_e2", bus.moving, 1'b1);
        chk("t1_gf", bus.gf, 2'b10);
        chk("t1_dir", bus.dir, 1'b1);
        tick(3);                                       // e5
        chk("t1_fl_e5", bus.floor, 2'b00);
        tick(1);                                       // e6
        chk("t1_fl_e6", bus.floor, 2'b01);
        chk("t1_mv_e6", bus.moving, 1'b1);
        tick(3);                                       // e9
        chk("t1_fl_e9", bus.floor, 2'b01);
        tick(1);                                       // e10
        chk("t1_fl_e10", bus.floor, 2'b10);
        chk("t1_leds_e10", leds(), 3'b000);
        chk("t1_door_e10", bus.door_open, 1'b1);
        chk("t1_mv_e10", bus.moving, 1'b0);
        tick(2);                                       // e12
        chk("t1_door_e12", bus.door_open, 1'b1);
        tick(1);                                       // e13
        chk("t1_door_e13", bus.door_open, 1'b0);

        // Back down to F1
        press(3'b001);                                 // e1
        tick(1);                                       // e2
        chk("dn_dir", bus.dir, 1'b0);
        chk("dn_gf", bus.gf, 2'b00);
        tick(8);                                       // e10
        chk("dn_floor", bus.floor, 2'b00);
        chk("dn_door", bus.door_open, 1'b1);
        tick(3);                                       // e13
        chk("dn_closed", bus.door_open, 1'b0);

        // F1 -> F3 with an F2 call picked up on the way
        press(3'b100);                                 // e1
        tick(1);                                       // e2
        press(3'b010);                                 // e3
        chk("t2_leds_e3", leds(), 3'b110);
        tick(3);                                       // e6
        chk("t2_fl_e6", bus.floor, 2'b01);
        chk("t2_leds_e6", leds(), 3'b100);
        chk("t2_door_e6", bus.door_open, 1'b1);
        chk("t2_mv_e6", bus.moving, 1'b0);
        chk("t2_gf_e6", bus.gf, 2'b10);
        tick(3);                                       // e9
        chk("t2_door_e9", bus.door_open, 1'b0);
        chk("t2_mv_e9", bus.moving, 1'b0);
        tick(1);                                       // e10
        chk("t2_mv_e10", bus.moving, 1'b1);
        tick(4);                                       // e14
        chk("t2_fl_e14", bus.floor, 2'b10);
        chk("t2_door_e14", bus.door_open, 1'b1);
        chk("t2_leds_e14", leds(), 3'b000);
        tick(3);                                       // e17

        // Reposition: F3 -> F1, then F1 -> F2 (leaves dir=up at F2)
        press(3'b001);
        tick(12);
        chk("rp_floor_f1", bus.floor, 2'b00);
        press(3'b010);
        tick(8);
        chk("rp_floor_f2", bus.floor, 2'b01);
        chk("rp_dir", bus.dir, 1'b1);
        chk("rp_door", bus.door_open, 1'b0);

        // SCAN at F2, dir=up, calls F1 and F3: F3 first
        press(3'b101);                                 // e1
        chk("t3_leds_e1", leds(), 3'b101);
        tick(1);                                       // e2
        chk("t3_gf_e2", bus.gf, 2'b10);
        chk("t3_dir_e2", bus.dir, 1'b1);
        tick(4);                                       // e6
        chk("t3_fl_e6", bus.floor, 2'b10);
        chk("t3_leds_e6", leds(), 3'b001);
        tick(3);                                       // e9
        tick(1);                                       // e10
        chk("t3_gf_e10", bus.gf, 2'b00);
        chk("t3_dir_e10", bus.dir, 1'b0);
        chk("t3_mv_e10", bus.moving, 1'b1);
        tick(4);                                       // e14
        chk("t3_fl_e14", bus.floor, 2'b01);
        chk("t3_mv_e14", bus.moving, 1'b1);
        tick(4);                                       // e18
        chk("t3_fl_e18", bus.floor, 2'b00);
        chk("t3_door_e18", bus.door_open, 1'b1);
        chk("t3_leds_e18", leds(), 3'b000);
        tick(3);                                       // e21

        // Call at the current floor while idle, then repeat press during dwell
        press(3'b001);                                 // e1
        chk("t4_door_e1", bus.door_open, 1'b1);
        chk("t4_leds_e1", leds(), 3'b000);
        tick(1);                                       // e2
        press(3'b001);                                 // e3, reload dwell
        chk("t4_leds_e3", leds(), 3'b000);
        tick(1);                                       // e4
        chk("t4_door_e4", bus.door_open, 1'b1);
        tick(1);                                       // e5
        chk("t4_door_e5", bus.door_open, 1'b1);
        tick(1);                                       // e6
        chk("t4_door_e6", bus.door_open, 1'b0);

        // Call for F2 landing in the very cycle the car arrives there
        press(3'b100);                                 // e1
        tick(3);                                       // e4
        tick(1);                                       // e5
        press(3'b010);                                 // e6
        chk("t5_fl_e6", bus.floor, 2'b01);
        chk("t5_leds_e6", leds(), 3'b100);
        chk("t5_door_e6", bus.door_open, 1'b1);
        tick(3);                                       // e9
        tick(5);                                       // e14
        chk("t5_fl_e14", bus.floor, 2'b10);
        tick(3);                                       // e17

        // Reset in mid-travel
        press(3'b001);                                 // e1
        tick(4);                                       // e5
        chk("t6_mv_e5", bus.moving, 1'b1);
        rst = 1'b1;
        tick(1);                                       // e6
        chk("t6_floor", bus.floor, 2'b00);
        chk("t6_leds", leds(), 3'b000);
        chk("t6_moving", bus.moving, 1'b0);
        chk("t6_dir", bus.dir, 1'b1);
        chk("t6_door", bus.door_open, 1'b0);
        chk("t6_gf", bus.gf, 2'b00);
        rst = 1'b0;
        tick(3);
        chk("t6_after_mv", bus.moving, 1'b0);
        chk("t6_after_leds", leds(), 3'b000);

`ifdef ELEVATOR_ESTOP_EN
        // Estop for 5 clocks mid-travel delays arrival by 5
        press(3'b010);                                 // e1
        tick(2);                                       // e3
        chk("es_mv_e3", bus.moving, 1'b1);
        bus.estop = 1'b1;
        tick(1);                                       // e4
        chk("es_mv_e4", bus.moving, 1'b0);
        tick(4);                                       // e8
        chk("es_mv_e8", bus.moving, 1'b0);
        chk("es_fl_e8", bus.floor, 2'b00);
        bus.estop = 1'b0;
        tick(1);                                       // e9
        chk("es_mv_e9", bus.moving, 1'b1);
        tick(1);                                       // e10
        chk("es_fl_e10", bus.floor, 2'b00);
        tick(1);                                       // e11
        chk("es_fl_e11", bus.floor, 2'b01);
        chk("es_door_e11", bus.door_open, 1'b1);
        tick(3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
